pin_id_tx: RTL and testbench

- Drive-side board bring-up block: every output pin continuously transmits its own index as UART 8N1 frames.
- Probing any pad with a scope or UART dongle identifies which FPGA pin it is.
- Companion to the all-inputs bring-up top, used for the reverse check of the FPGA-to-board pin map.
- Sits in a bring-up top, clocked from clk25; outputs go straight to pads.

---
 rtl/pin_id_tx.sv | 106 ++++++++++
 tb/tb_pin_id_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_id_tx.sv
// pin_id_tx: every pin endlessly sends its own 16-bit index as two UART 8N1 bytes followed by an idle gap.
// Define PIN_ID_PARITY_EN to switch every byte to 8E1 (even parity bit after bit 7).
module pin_id_tx #(
  parameter int NUM_PINS = 8,
  parameter int CLK_DIV  = 217,
  parameter int GAP_BITS = 4
) (
  input  logic                clk25,
  input  logic                rst_,
  input  logic                enable,
  output logic [NUM_PINS-1:0] pins,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_cnt
);
`ifdef PIN_ID_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP, DONE} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, DONE} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0] idx, idx_nxt;
  logic bsel, bsel_nxt, tick;
  logic [NUM_PINS-1:0] pins_nxt;

  assign tick = cnt == 16'(CLK_DIV - 1);

  always_ff @(posedge clk25 or negedge rst_)
    if (!rst_) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      bsel      <= 1'b0;
      frame_cnt <= '0;
      pins      <= '1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      bsel      <= bsel_nxt;
      frame_cnt <= state == DONE ? frame_cnt + 8'd1 : frame_cnt;
      pins      <= pins_nxt;
    end

  // idx is shared: data bit index inside a byte, gap bit count inside GAP
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bsel_nxt  = bsel;
    cnt_nxt   = (state == IDLE || state == DONE || tick) ? '0 : cnt + 16'd1;
    case (state)
      IDLE: if (enable) begin
        state_nxt = START;
        bsel_nxt  = 1'b0;
      end
      START: if (tick) begin
        state_nxt = DATA;
        idx_nxt   = '0;
      end
      DATA: if (tick) begin
        idx_nxt = idx + 8'd1;
        if (idx == 8'd7) state_nxt = AFTER_DATA;
      end
`ifdef PIN_ID_PARITY_EN
      PARITY: if (tick) state_nxt = STOP;
`endif
      STOP: if (tick) begin
        bsel_nxt  = 1'b1;
        idx_nxt   = '0;
        state_nxt = !bsel ? START : (GAP_BITS == 0 ? DONE : GAP);
      end
      GAP: if (tick) begin
        idx_nxt = idx + 8'd1;
        if (idx == 8'(GAP_BITS - 1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = enable ? START : IDLE;
        bsel_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = state != IDLE;
    frame_done = state == DONE;
  end

  // pins are registered from next-state values, so the start bit lands one cycle after enable is seen
  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    localparam logic [15:0] ID = 16'(i);
    logic [7:0] b;
    assign b = bsel_nxt ? ID[15:8] : ID[7:0];
`ifdef PIN_ID_PARITY_EN
    assign pins_nxt[i] = state_nxt == START  ? 1'b0 :
                         state_nxt == DATA   ? b[idx_nxt[2:0]] :
                         state_nxt == PARITY ? ^b : 1'b1;
`else
    assign pins_nxt[i] = state_nxt == START ? 1'b0 :
                         state_nxt == DATA  ? b[idx_nxt[2:0]] : 1'b1;
`endif
  end
endmodule

// File: tb/tb_pin_id_tx.sv
// tb_pin_id_tx: directed bench for pin_id_tx; checks waveforms against a cycle-indexed UART frame model.
module tb_pin_id_tx;
`ifdef PIN_ID_PARITY_EN
  localparam int NP = 8, W = 11;
`else
  localparam int NP = 4, W = 10;
`endif
  localparam int CD = 4, GB = 2, FL = CD * (2 * W + GB) + 1;

  logic clk25 = 1'b0, rst_ = 1'b0, enable = 1'b0;
  logic [NP-1:0] pins;
  logic busy, frame_done;
  logic [7:0] frame_cnt;
  int checks = 0, errors = 0;

  logic [NP-1:0] lg [1:FL+1];
  logic fd [1:FL+1];
  logic bz [1:FL+1];
  logic [7:0] cn [1:FL+1];

  pin_id_tx #(.NUM_PINS(NP), .CLK_DIV(CD), .GAP_BITS(GB)) dut (
    .clk25(clk25), .rst_(rst_), .enable(enable), .pins(pins),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // expected level of pin p in cycle c (1 = first start-bit cycle) of a frame
  function automatic logic exp_pin(int p, int c);
    int k = (c - 1) / CD;
    int j;
    logic [7:0] by;
    if (k >= 2 * W) return 1'b1;
    j  = k % W;
    by = (k / W) != 0 ? 8'(p >> 8) : 8'(p);
    if (j == 0) return 1'b0;
    if (j <= 8) return by[j-1];
    if (W == 11 && j == 9) return ^by;
    return 1'b1;
  endfunction

  function automatic logic [NP-1:0] exp_vec(int c);
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = exp_pin(p, c);
    return v;
  endfunction

  function automatic logic slot_bit(int p, int s);
    return lg[1 + s * CD + CD / 2][p];
  endfunction

  function automatic logic [7:0] dec(int p, int b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = slot_bit(p, b * W + 1 + k);
    return r;
  endfunction

  task automatic do_reset();
    rst_ = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk25);
    rst_ = 1'b1;
    @(negedge clk25);
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    enable = 1'b1;
    repeat (4) begin
      @(negedge clk25);
      checks++;
      if (pins !== '1 || busy !== 1'b0 || frame_cnt !== 8'd0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: pins=%b busy=%b cnt=%0d done=%b, want all 1/0/0/0", pins, busy, frame_cnt, frame_done);
      end
    end
    enable = 1'b0;
    rst_ = 1'b1;
    repeat (3) @(negedge clk25);
    checks++;
    if (pins !== '1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: pins=%b busy=%b, want all 1/0", pins, busy);
    end
  endtask

  task automatic test_single_frame();
    int bad = 0, nd = 0, pos = 0;
    @(negedge clk25);
    enable = 1'b1;
    @(negedge clk25);
    enable = 1'b0;
    for (int c = 1; c <= FL + 1; c++) begin
      lg[c] = pins;
      fd[c] = frame_done;
      bz[c] = busy;
      cn[c] = frame_cnt;
      @(negedge clk25);
    end
    for (int c = 1; c <= FL; c++) if (lg[c] !== exp_vec(c)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_wave: %0d cycles differ, want 0", bad);
    end
    bad = 0;
    for (int c = 1; c <= FL; c++) if (bz[c] !== 1'b1) bad++;
    checks++;
    if (bad != 0 || bz[FL+1] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: %0d low-in-frame cycles, after=%b, want 0 and 0", bad, bz[FL+1]);
    end
    for (int c = 1; c <= FL + 1; c++) if (fd[c] === 1'b1) begin nd++; pos = c; end
    checks++;
    if (nd != 1 || pos != FL) begin
      errors++;
      $display("FAIL single_done: %0d pulses at cycle %0d, want 1 at %0d", nd, pos, FL);
    end
    checks++;
    if (cn[FL] !== 8'd0 || cn[FL+1] !== 8'd1) begin
      errors++;
      $display("FAIL single_cnt: %0d then %0d, want 0 then 1", cn[FL], cn[FL+1]);
    end
    checks++;
    if (dec(2, 0) !== 8'h02 || dec(2, 1) !== 8'h00) begin
      errors++;
      $display("FAIL decode_pin2: %h %h, want 02 00", dec(2, 0), dec(2, 1));
    end
    checks++;
    if (dec(3, 0) !== 8'h03 || dec(3, 1) !== 8'h00) begin
      errors++;
      $display("FAIL decode_pin3: %h %h, want 03 00", dec(3, 0), dec(3, 1));
    end
    checks++;
    if (slot_bit(2, 0) !== 1'b0 || slot_bit(2, W - 1) !== 1'b1 || slot_bit(2, W) !== 1'b0 || slot_bit(2, 2 * W - 1) !== 1'b1) begin
      errors++;
      $display("FAIL framing_pin2: start/stop/start/stop=%b%b%b%b, want 0101",
               slot_bit(2, 0), slot_bit(2, W - 1), slot_bit(2, W), slot_bit(2, 2 * W - 1));
    end
`ifdef PIN_ID_PARITY_EN
    checks++;
    if (slot_bit(7, 9) !== 1'b1) begin
      errors++;
      $display("FAIL parity_pin7: %b, want 1", slot_bit(7, 9));
    end
    checks++;
    if (slot_bit(3, 9) !== 1'b0) begin
      errors++;
      $display("FAIL parity_pin3: %b, want 0", slot_bit(3, 9));
    end
`endif
    bad = 0;
    repeat (2 * FL) begin
      if (pins !== '1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
      @(negedge clk25);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_quiet: %0d active cycles after frame, want 0", bad);
    end
  endtask

  task automatic test_continuous();
    int c = 1, nd = 0, bad = 0, badcnt = 0;
    bit chk_wrap = 0;
    do_reset();
    enable = 1'b1;
    @(negedge clk25);
    for (int t = 0; t < 300 * FL + 10 && nd < 300; t++) begin
      if (chk_wrap) begin
        chk_wrap = 0;
        checks++;
        if (frame_cnt !== 8'd0) begin
          errors++;
          $display("FAIL cnt_wrap: %0d after 256 frames, want 0", frame_cnt);
        end
      end
      if (pins !== exp_vec(c) || busy !== 1'b1 || frame_done !== (c == FL)) bad++;
      if (frame_cnt !== 8'(nd)) badcnt++;
      if (frame_done === 1'b1) begin
        nd++;
        if (nd == 256) chk_wrap = 1;
        if (nd == 300) enable = 1'b0;
      end
      c = c == FL ? 1 : c + 1;
      @(negedge clk25);
    end
    checks++;
    if (nd != 300) begin
      errors++;
      $display("FAIL cont_frames: %0d frames seen, want 300", nd);
    end
    checks++;
    if (bad != 0 || badcnt != 0) begin
      errors++;
      $display("FAIL cont_wave: %0d wave and %0d count mismatches, want 0", bad, badcnt);
    end
    checks++;
    if (frame_cnt !== 8'd44 || busy !== 1'b0 || pins !== '1) begin
      errors++;
      $display("FAIL cont_end: cnt=%0d busy=%b pins=%b, want 44/0/all 1", frame_cnt, busy, pins);
    end
  endtask

  task automatic test_mid_disable();
    int bad = 0;
    do_reset();
    enable = 1'b1;
    @(negedge clk25);
    for (int c = 1; c <= FL; c++) begin
      if (pins !== exp_vec(c) || busy !== 1'b1 || frame_done !== (c == FL)) bad++;
      if (c == 4 * CD + 2) enable = 1'b0;
      @(negedge clk25);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL disable_wave: %0d mismatching cycles, want 0", bad);
    end
    bad = 0;
    repeat (3 * FL) begin
      if (pins !== '1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
      @(negedge clk25);
    end
    checks++;
    if (bad != 0 || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL disable_idle: %0d active cycles, cnt=%0d, want 0 and 1", bad, frame_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    enable = 1'b1;
    @(negedge clk25);
    repeat (FL + 2 * CD + 1) @(negedge clk25);
    checks++;
    if (busy !== 1'b1 || frame_cnt !== 8'd1 || pins !== exp_vec(2 * CD + 2)) begin
      errors++;
      $display("FAIL pre_reset: busy=%b cnt=%0d pins=%b, want 1/1/%b", busy, frame_cnt, pins, exp_vec(2 * CD + 2));
    end
    rst_ = 1'b0;
    #1;
    checks++;
    if (pins !== '1 || busy !== 1'b0 || frame_cnt !== 8'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pins=%b busy=%b cnt=%0d done=%b, want all 1/0/0/0", pins, busy, frame_cnt, frame_done);
    end
    repeat (2) @(negedge clk25);
    rst_ = 1'b1;
    #1;
    checks++;
    if (pins !== '1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: pins=%b busy=%b, want all 1/0", pins, busy);
    end
    @(negedge clk25);
    checks++;
    if (pins !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL release_start: pins=%b busy=%b, want all 0/1", pins, busy);
    end
    enable = 1'b0;
    while (busy === 1'b1 && n < FL + 5) begin
      @(negedge clk25);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL release_frame: busy=%b cnt=%0d after %0d cycles, want 0 and 1", busy, frame_cnt, n);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_mid_disable();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
